// File: rtl/sad_pkg.sv
// sad_pkg: shared widths, the SAD saturation value and FSM state codes for the SAD search sequencer.
package sad_pkg;

  localparam int SAD_W = 14;
  localparam int IDX_W = 16;

  localparam logic [SAD_W-1:0] SAD_MAX = 14'h3FFF;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/sad_valid_pipe.sv
// sad_valid_pipe: PIPE_LAT-deep {valid, last} shift register that tracks each issue slot
// alongside the SAD core's fixed pipeline, so results can be qualified at the tap.
module sad_valid_pipe #(
  parameter int PIPE_LAT = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  logic [PIPE_LAT-1:0] r_valid;
  logic [PIPE_LAT-1:0] r_last;

  // Stage 0 captures the slot; each stage then advances one cycle toward the tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign o_valid = r_valid[PIPE_LAT-1];
  assign o_last  = r_last[PIPE_LAT-1];

endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: raster-scan sequencer for the 4-thread SAD core with running-minimum fold.
// Optional macro SAD_EARLY_EXIT_EN adds Threshold/EarlyExit early termination of the scan.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int FRAME_W  = 64,
  parameter int FRAME_H  = 64,
  parameter int WIN      = 4,
  parameter int PIPE_LAT = 7
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             FrameReady,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_W-1:0] Threshold,
  output logic             EarlyExit,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [IDX_W-1:0] BestIndex,
  output logic [SAD_W-1:0] BestValue,
  output logic             SeqError,
  output logic [IDX_W-1:0] CoreIndex,
  output logic             CoreTriggerBoss,
  input  logic [IDX_W-1:0] CoreOutIndex,
  input  logic [SAD_W-1:0] CoreOutValue,
  input  logic             CoreOutTriggerBoss
);

  localparam int LOG2W = $clog2(FRAME_W);
  // Last base x leaves room for the core's four adjacent candidates inside the frame.
  localparam logic [IDX_W-1:0] X_LAST = IDX_W'(FRAME_W - WIN - 3);
  localparam logic [IDX_W-1:0] Y_LAST = IDX_W'(FRAME_H - WIN);
  localparam logic [IDX_W-1:0] X_STEP = 16'd4;

  state_t           r_state;
  logic [IDX_W-1:0] r_x;
  logic [IDX_W-1:0] r_y;
  logic [IDX_W-1:0] r_core_index;
  logic [IDX_W-1:0] r_best_index;
  logic [SAD_W-1:0] r_best_value;
  logic             r_seq_err;
  logic             r_done;
  logic             r_busy;

  logic [IDX_W-1:0] w_x_nxt;
  logic [IDX_W-1:0] w_y_nxt;
  logic [IDX_W-1:0] w_index_nxt;
  logic             w_at_last;
  logic             w_stop;
  logic             w_issue;
  logic             w_pipe_last;
  logic             w_tap_valid;
  logic             w_tap_last;
  logic             w_better;

`ifdef SAD_EARLY_EXIT_EN
  logic [SAD_W-1:0] r_threshold;
  logic             r_early_exit;

  assign w_stop    = (r_state == ISSUE) && (r_best_value <= r_threshold);
  assign EarlyExit = r_early_exit;
`else
  assign w_stop = 1'b0;
`endif

  assign w_at_last   = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_issue     = (r_state == ISSUE) && FrameReady && !w_stop;
  // An early stop attaches the last marker to a bubble so the drain still terminates.
  assign w_pipe_last = (w_issue && w_at_last) || w_stop;
  assign w_index_nxt = (w_y_nxt << LOG2W) + w_x_nxt;
  assign w_better    = w_tap_valid && (CoreOutValue < r_best_value);

  // Next scan position: step x by four, clamp to the final base, then wrap to the next row.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_x == X_LAST) begin
      w_x_nxt = '0;
      w_y_nxt = r_y + 16'd1;
    end else if ((r_x + X_STEP) > X_LAST) begin
      w_x_nxt = X_LAST;
    end else begin
      w_x_nxt = r_x + X_STEP;
    end
  end

  sad_valid_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst_n  (Rst_n),
    .i_valid(w_issue),
    .i_last (w_pipe_last),
    .o_valid(w_tap_valid),
    .o_last (w_tap_last)
  );

  // Search FSM, scan counters, running-minimum fold and sticky sequence check.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_core_index <= '0;
      r_best_index <= '0;
      r_best_value <= SAD_MAX;
      r_seq_err    <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
      r_threshold  <= '0;
      r_early_exit <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state      <= ISSUE;
            r_busy       <= 1'b1;
            r_x          <= '0;
            r_y          <= '0;
            r_core_index <= '0;
            r_best_index <= '0;
            r_best_value <= SAD_MAX;
            r_seq_err    <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            r_threshold  <= Threshold;
            r_early_exit <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (w_stop) begin
            r_state <= DRAIN;
`ifdef SAD_EARLY_EXIT_EN
            r_early_exit <= 1'b1;
`endif
          end else if (w_issue) begin
            if (w_at_last) begin
              r_state <= DRAIN;
            end else begin
              r_x          <= w_x_nxt;
              r_y          <= w_y_nxt;
              r_core_index <= w_index_nxt;
            end
          end
        end
        DRAIN: begin
          if (w_tap_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_better) begin
        r_best_value <= CoreOutValue;
        r_best_index <= CoreOutIndex;
      end
      if (w_tap_valid && (CoreOutTriggerBoss != w_tap_last)) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign Busy            = r_busy;
  assign Done            = r_done;
  assign BestIndex       = r_best_index;
  assign BestValue       = r_best_value;
  assign SeqError        = r_seq_err;
  assign CoreIndex       = r_core_index;
  assign CoreTriggerBoss = w_issue && w_at_last;

endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Sequencer for the 4-thread SAD core (16-pixel window vs. 4x4 frame blocks, four horizontally adjacent candidates per issue).
- Raster-scans all candidate positions of one frame and drives the core's Index/TriggerBoss each issue slot.
- Tracks in-flight issues through the core's fixed pipeline and folds core results into a running minimum.
- Reports the best candidate index and SAD value with a done pulse; upstream frame/window fetch follows CoreIndex.

Parameters:
- FRAME_W, 64, frame row stride and width in pixels (power of two, >= 8).
- FRAME_H, 64, frame height in rows.
- WIN, 4, window edge in pixels (core is fixed at 4).
- PIPE_LAT, 7, cycles from CoreIndex issue to matching CoreOut result.

Ports:
- clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin a search; sampled only in IDLE.
- FrameReady  in  1  frame/window data for the current CoreIndex is valid this cycle.
- Busy  out  1  high in ISSUE or DRAIN.
- Done  out  1  one-cycle pulse when the result is final.
- BestIndex  out  16  index of the minimum-SAD candidate.
- BestValue  out  14  minimum SAD value.
- SeqError  out  1  sticky; the core's trigger disagreed with the internal last marker.
- CoreIndex  out  16  base candidate index to the core, = y*FRAME_W + x.
- CoreTriggerBoss  out  1  high on the final issue of a search.
- CoreOutIndex  in  16  core result index.
- CoreOutValue  in  14  core result SAD.
- CoreOutTriggerBoss  in  1  core-delayed trigger.

Behaviour:
- Reset values: state IDLE; all outputs 0; BestValue 14'h3FFF; valid/last shift registers cleared. Reset mid-search abandons the search with no Done pulse.
- Scan order:
  - x steps 0, 4, 8, ... up to the largest multiple of 4 that is <= FRAME_W-WIN-3, then one final x = FRAME_W-WIN-3 (57 at defaults). Overlapping candidates are harmless.
  - y runs 0..FRAME_H-WIN, row-major.
  - Defaults: 16 issues/row, 61 rows, 976 issues.
- States:
  - IDLE: Start=1 -> ISSUE. Clear BestValue to 3FFF, BestIndex to 0, x=y=0.
  - ISSUE: CoreIndex always shows the current candidate.
    - An issue occurs in a cycle where FrameReady=1. The valid bit enters the shift register and the scan advances.
    - When FrameReady=0, a bubble (valid=0) is inserted and the scan holds.
    - CoreTriggerBoss=1 only during the cycle the last candidate issues; next state DRAIN.
  - DRAIN: no issues; CoreIndex holds its last value. Exits when the last-marker reaches the shift register tap -> DONE.
  - DONE: Done=1 for one cycle, -> IDLE. BestIndex/BestValue hold until the next Start.
- Result fold:
  - At tap valid=1, compare CoreOutValue < BestValue (strict). The earliest candidate wins ties.
  - Update both registers in the same cycle. The final tap result is included before Done.
- Latency: with FrameReady constantly 1, Start at cycle 0 gives issues in cycles 1..976. The last result is at the tap in cycle 976+PIPE_LAT; Done is asserted in cycle 977+PIPE_LAT.
- SeqError: set when tap valid=1 and CoreOutTriggerBoss differs from the tap last-marker. Cleared only by reset or by Start.
- Start while Busy or in DONE: ignored.
- Width rules: x, y are 16-bit counters; CoreIndex = (y << log2(FRAME_W)) + x with no overflow for legal parameters.

Optional Feature:
- Macro SAD_EARLY_EXIT_EN.
- Defined:
  - Adds input Threshold[13:0] (sampled at Start) and output EarlyExit (1).
  - In ISSUE, once BestValue <= Threshold, issuing stops. The next cycle issues no further candidates, and the last marker is attached to a bubble slot.
  - The FSM then enters DRAIN; results still in flight continue to be folded. Done is asserted with EarlyExit=1.
  - EarlyExit resets to 0 and is cleared at Start.
- Undefined: no Threshold/EarlyExit ports; the full scan always runs.

Decomposition:
- Package sad_pkg: SAD_W=14, IDX_W=16, SAD_MAX=14'h3FFF, state enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module: sad_valid_pipe. It is a PIPE_LAT-deep shift register of {valid, last} with async active-low reset.

Test Plan:
- Defaults, FrameReady=1, core model returns SAD = |index-1234| with a single zero at index 1234 -> exactly 976 issues, BestIndex=1234, BestValue=0, Done at cycle 977+PIPE_LAT, SeqError=0.
- FrameReady toggling 1/0 every cycle -> 976 issues over 1951 cycles, same result, no result folded from bubble slots.
- Equal minimum 100 at indices 200 and 900 -> BestIndex=200, BestValue=100.
- Rst_n low during DRAIN -> outputs return to reset values immediately; no Done; a subsequent Start runs a clean search.
- Core model drops CoreOutTriggerBoss on the last result -> SeqError=1, still asserted after Done; next Start clears it.
- SAD_EARLY_EXIT_EN, Threshold=50, zero at index 130 -> issues stop after index 130 is folded; Done with EarlyExit=1, BestIndex=130.
